sr_out_block_sink: RTL and testbench



---
 rtl/sr_out_block_sink.sv | 139 +++++++++++++
 tb/tb_sr_out_block_sink.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_out_block_sink.sv
// Output-stream sink for top_sr: collects SIZE x SIZE filtered blocks into a
// ping-pong buffer and serves completed blocks through a random-access read port.
module sr_out_block_sink #(
  parameter int DATA_W   = 8,
  parameter int DIN_W    = 8,
  parameter int SIZE_MAX = 64,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        cfg_size,
  input  logic              cfg_write,
  input  logic [DIN_W-1:0]  din,
  input  logic              write,
  output logic              full,
  output logic              blk_ready,
  output logic [6:0]        blk_size,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release,
  output logic [15:0]       blk_count,
  output logic              cfg_err
);

  localparam int DEPTH = SIZE_MAX * SIZE_MAX;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } bank_state_t;

  bank_state_t       bank_state     [2];
  bank_state_t       bank_state_nxt [2];
  logic [6:0]        bank_size      [2];
  logic [6:0]        pending_size;
  logic [6:0]        pending_nxt;
  logic [6:0]        active_size;
  logic [6:0]        cur_size;
  logic [ADDR_W-1:0] cnt;
  logic              wr_bank;
  logic              wr_bank_nxt;
  logic              rd_bank;
  logic              rd_bank_nxt;
  logic              cfg_legal;
  logic              accept;
  logic              first_pixel;
  logic              last_pixel;
  logic              release_ok;
  logic              full_nxt;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  // Configuration legality and handshake decode.
  always_comb begin
    cfg_legal = 1'b0;
    if ((cfg_size == 7'd4) || (cfg_size == 7'd8) || (cfg_size == 7'd16) ||
        (cfg_size == 7'd32) || (cfg_size == 7'd64))
      cfg_legal = (32'(cfg_size) <= SIZE_MAX);
  end

  // The first pixel of a block uses the pending size; later pixels use the latched one.
  always_comb begin
    accept      = write & ~full;
    first_pixel = (cnt == '0);
    cur_size    = first_pixel ? pending_size : active_size;
    last_pixel  = accept &&
                  (32'(cnt) == (32'(cur_size) * 32'(cur_size)) - 32'd1);
    release_ok  = rd_release && (bank_state[rd_bank] == BANK_READY);
  end

  // Next-state of both banks, bank pointers, pending size and the full flag.
  always_comb begin
    bank_state_nxt = bank_state;
    if (accept)
      bank_state_nxt[wr_bank] = last_pixel ? BANK_READY : BANK_FILLING;
    if (release_ok)
      bank_state_nxt[rd_bank] = BANK_EMPTY;
    wr_bank_nxt = wr_bank ^ last_pixel;
    rd_bank_nxt = rd_bank ^ release_ok;
    pending_nxt = (cfg_write && cfg_legal) ? cfg_size : pending_size;
    full_nxt    = (pending_nxt == 7'd0) ||
                  (bank_state_nxt[wr_bank_nxt] == BANK_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      bank_size[0]  <= 7'd0;
      bank_size[1]  <= 7'd0;
      pending_size  <= 7'd0;
      active_size   <= 7'd0;
      cnt           <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full          <= 1'b1;
      blk_count     <= 16'd0;
      cfg_err       <= 1'b0;
    end else begin
      bank_state   <= bank_state_nxt;
      wr_bank      <= wr_bank_nxt;
      rd_bank      <= rd_bank_nxt;
      pending_size <= pending_nxt;
      full         <= full_nxt;
      if (cfg_write && !cfg_legal)
        cfg_err <= 1'b1;
      if (accept) begin
        if (first_pixel)
          active_size <= pending_size;
        if (last_pixel) begin
          cnt                <= '0;
          bank_size[wr_bank] <= cur_size;
          blk_count          <= blk_count + 16'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Pixel storage has no reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept && !rst)
      mem[{wr_bank, cnt}] <= din[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[{rd_bank, rd_addr}];
  end

  assign blk_ready = (bank_state[rd_bank] == BANK_READY);
  assign blk_size  = bank_size[rd_bank];

endmodule

// File: tb/tb_sr_out_block_sink.sv
// Randomized bench for sr_out_block_sink: a queue-based block model predicts flags,
// and a scoreboard checks every read against the model's completed blocks.
module tb_sr_out_block_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  cfg_size = 7'd0;
  logic        cfg_write = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        write = 1'b0;
  logic        full;
  logic        blk_ready;
  logic [6:0]  blk_size;
  logic [11:0] rd_addr = 12'd0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_release = 1'b0;
  logic [15:0] blk_count;
  logic        cfg_err;

  sr_out_block_sink dut (
    .clk(clk), .rst(rst), .cfg_size(cfg_size), .cfg_write(cfg_write),
    .din(din), .write(write), .full(full), .blk_ready(blk_ready),
    .blk_size(blk_size), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_release(rd_release), .blk_count(blk_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: pending size, the partial block, and completed blocks in order.
  int         m_pending = 0;
  int         m_active  = 0;
  int         m_count   = 0;
  int         m_accepted = 0;
  bit         m_err     = 1'b0;
  logic [7:0] cur_pix[$];
  logic [7:0] ready_pix[$];
  int         ready_sz[$];

  logic [7:0] exp_q[$];
  logic       rd_chk   = 1'b0;
  logic       rd_chk_d = 1'b0;

  function automatic bit legalSize(int s);
    return (s == 4) || (s == 8) || (s == 16) || (s == 32) || (s == 64);
  endfunction

  function automatic bit modelFull();
    return (m_pending == 0) || (ready_sz.size() == 2);
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    assert_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState();
    checkOutput("full", int'(full), int'(modelFull()));
    checkOutput("blk_ready", int'(blk_ready), int'(ready_sz.size() > 0));
    checkOutput("blk_count", int'(blk_count), m_count & 16'hFFFF);
    checkOutput("cfg_err", int'(cfg_err), int'(m_err));
    if (ready_sz.size() > 0)
      checkOutput("blk_size", int'(blk_size), ready_sz[0]);
  endtask

  task automatic modelUpdate(bit r, bit cw, int cs, bit w, logic [7:0] d, bit rel);
    if (r) begin
      m_pending = 0;
      m_active  = 0;
      m_count   = 0;
      m_err     = 1'b0;
      cur_pix.delete();
      ready_pix.delete();
      ready_sz.delete();
      return;
    end
    if (w && !modelFull()) begin
      if (cur_pix.size() == 0)
        m_active = m_pending;
      cur_pix.push_back(d);
      m_accepted++;
      if (cur_pix.size() == m_active * m_active) begin
        foreach (cur_pix[i]) ready_pix.push_back(cur_pix[i]);
        cur_pix.delete();
        ready_sz.push_back(m_active);
        m_count++;
      end
    end
    if (rel && ready_sz.size() > 0) begin
      repeat (ready_sz[0] * ready_sz[0]) void'(ready_pix.pop_front());
      void'(ready_sz.pop_front());
    end
    if (cw) begin
      if (legalSize(cs)) m_pending = cs;
      else m_err = 1'b1;
    end
  endtask

  // One clock of stimulus: check state, drive inputs, advance model at the edge.
  task automatic applyStimulus(bit r, bit cw, int cs, bit w, logic [7:0] d,
                               bit rel, bit re, int ra);
    checkState();
    rst        = r;
    cfg_write  = cw;
    cfg_size   = 7'(cs);
    write      = w;
    din        = d;
    rd_release = rel;
    rd_en      = re;
    rd_addr    = 12'(ra);
    rd_chk     = 1'b0;
    if (!r && re && ready_sz.size() > 0 && ra < ready_sz[0] * ready_sz[0]) begin
      exp_q.push_back(ready_pix[ra]);
      rd_chk = 1'b1;
    end
    @(posedge clk);
    modelUpdate(r, cw, cs, w, d, rel);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 8'd0, 0, 0, 0);
  endtask

  task automatic randomRead(output bit re, output int ra);
    re = ($urandom_range(0, 1) == 1);
    if (ready_sz.size() > 0) ra = int'($urandom_range(0, ready_sz[0] * ready_sz[0] - 1));
    else ra = int'($urandom_range(0, 4095));
  endtask

  // Push n pixels with random gaps, reads and (optionally) releases.
  task automatic sendPixels(int n, int rel_pct, int wr_pct, bit rand_din);
    int start = m_accepted;
    int budget = n * 4 + 200;
    bit re, w, rel;
    int ra;
    logic [7:0] d;
    while ((m_accepted - start) < n && budget > 0) begin
      randomRead(re, ra);
      w   = ($urandom_range(0, 99) < wr_pct);
      rel = ($urandom_range(0, 99) < rel_pct);
      d   = rand_din ? 8'($urandom) : 8'(m_accepted - start);
      applyStimulus(0, 0, 0, w, d, rel, re, ra);
      budget--;
    end
    if (budget == 0) begin
      fail_cnt++;
      $display("[TB] FAIL pixel_budget: got %0d pixels, expected %0d", m_accepted - start, n);
    end
  endtask

  task automatic drainAll();
    bit re;
    int ra;
    int guard = 4;
    while (ready_sz.size() > 0 && guard > 0) begin
      randomRead(re, ra);
      applyStimulus(0, 0, 0, 0, 8'd0, 1, re, ra);
      guard--;
    end
  endtask

  always @(posedge clk) rd_chk_d <= rd_chk;

  // Monitor: each checked read presents data one cycle later.
  always @(negedge clk) begin
    if (rd_chk_d) begin
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("[TB] FAIL rd_data: got %0d with no expected entry", rd_data);
      end else begin
        checkOutput("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_data_reset", int'(rd_data), 0);
    checkOutput("blk_size_reset", int'(blk_size), 0);

    // Writes before any configuration are refused.
    repeat (10) applyStimulus(0, 0, 0, 1, 8'h55, 0, 0, 0);

    // Smallest block, then read a known location.
    applyStimulus(0, 1, 4, 0, 8'd0, 0, 0, 0);
    sendPixels(16, 0, 100, 1'b0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 1, 5);
    idle(2);
    drainAll();

    // Two blocks without release fill both banks; the held pixel waits for a release.
    applyStimulus(0, 1, 16, 0, 8'd0, 0, 0, 0);
    sendPixels(512, 0, 100, 1'b0);
    repeat (3) applyStimulus(0, 0, 0, 1, 8'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'd0, 0, 1, 3);
    sendPixels(255, 0, 90, 1'b1);
    idle(1);
    drainAll();

    // A size change mid-block only affects the following block.
    applyStimulus(0, 1, 8, 0, 8'd0, 0, 0, 0);
    sendPixels(10, 0, 100, 1'b1);
    applyStimulus(0, 1, 32, 0, 8'd0, 0, 0, 0);
    sendPixels(54, 0, 80, 1'b1);
    sendPixels(1024, 2, 80, 1'b1);
    idle(1);
    drainAll();

    // Illegal size flags an error and keeps the previous pending size.
    applyStimulus(0, 1, 5, 0, 8'd0, 0, 0, 0);
    applyStimulus(0, 1, 100, 0, 8'd0, 0, 0, 0);
    applyStimulus(0, 1, 64, 0, 8'd0, 0, 0, 0);
    sendPixels(4096, 0, 100, 1'b1);
    idle(1);
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 1, 4095);
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 1, 0);
    idle(1);
    drainAll();

    // Reset mid-block throws away the partial block.
    applyStimulus(0, 1, 4, 0, 8'd0, 0, 0, 0);
    sendPixels(7, 0, 100, 1'b1);
    applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 0);
    checkOutput("rd_data_after_rst", int'(rd_data), 0);
    applyStimulus(0, 1, 4, 0, 8'd0, 0, 0, 0);
    sendPixels(16, 0, 100, 1'b1);
    for (int a = 0; a < 16; a++)
      applyStimulus(0, 0, 0, 0, 8'd0, 0, 1, a);
    drainAll();
    idle(3);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
